// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share a single alu, one operation in flight.
//
// A round-robin arbiter accepts one request while IDLE and registers the
// operands. The alu evaluates them during EXEC, and the registered result is
// returned over a valid/ready response channel in RESP.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   reqN_valid / reqN_ready       request handshake for requester N (0, 1)
//   reqN_op, reqN_a, reqN_b       opcode and operands of requester N
//   rsp_valid / rsp_ready         response handshake
//   rsp_id                        requester that issued the answered operation
//   rsp_out, rsp_flags, rsp_err   alu result, {V,C,N,Z} flags, illegal opcode
//
// Also contains the combinational alu used by the arbiter.

// Combinational alu.
// Opcodes: 0 ADD, 1 SUB, 2 LSL, 3 ASR, 4 LSR, 5 AND, 6 OR, 7 XOR, 8 EQUAL.
// The shift amount is the full b operand, so shifting by WORD_SIZE or more
// empties the word (ASR fills it with the sign bit).
module alu #(
  parameter int WORD_SIZE = 16
) (
  input  logic [3:0]           op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] out,
  output logic [3:0]           flags,
  output logic                 err
);

  localparam int MSB = WORD_SIZE - 1;

  logic [WORD_SIZE:0] sum;
  logic [WORD_SIZE:0] diff;
  logic               carry;
  logic               ovf;

  // The extra top bit of sum is the carry out. The extra top bit of diff is
  // the borrow, which is set exactly when a < b unsigned.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    out   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op)
      4'd0: begin
        out   = sum[MSB:0];
        carry = sum[WORD_SIZE];
        ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd1: begin
        out   = diff[MSB:0];
        carry = diff[WORD_SIZE];
        ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      4'd2: out = a << b;
      4'd3: out = WORD_SIZE'($signed(a) >>> b);
      4'd4: out = a >> b;
      4'd5: out = a & b;
      4'd6: out = a | b;
      4'd7: out = a ^ b;
      4'd8: out = {{(WORD_SIZE-1){1'b0}}, (a == b)};
      default: err = 1'b1;
    endcase
    // An illegal opcode reports all-zero flags, so Z is suppressed as well.
    flags = err ? 4'b0000 : {ovf, carry, out[MSB], (out == '0)};
  end

endmodule

module alu_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [3:0]           req0_op,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [3:0]           req1_op,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WORD_SIZE-1:0] rsp_out,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state;
  state_t               state_next;
  logic                 last_grant;
  logic                 grant_id;
  logic                 accept;
  logic [3:0]           op_q;
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic                 id_q;
  logic [WORD_SIZE-1:0] alu_out;
  logic [3:0]           alu_flags;
  logic                 alu_err;

  // Round-robin choice. On contention the requester that did not win last
  // time gets the grant. Otherwise the single valid requester gets it.
  // The result only matters when at least one requester is valid.
  always_comb begin
    grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  // Next-state and handshake logic. Readies are only raised in IDLE and
  // are gated by rst_n, so nothing is accepted in a reset cycle. rsp_valid
  // is gated the same way.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = rst_n;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand capture at the request handshake and result capture at the end
  // of EXEC. The response registers are untouched in RESP, which keeps them
  // stable during backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        id_q       <= grant_id;
        op_q       <= grant_id ? req1_op : req0_op;
        a_q        <= grant_id ? req1_a  : req0_a;
        b_q        <= grant_id ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        rsp_id    <= id_q;
        rsp_out   <= alu_out;
        rsp_flags <= alu_flags;
        rsp_err   <= alu_err;
      end
    end
  end

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .out   (alu_out),
    .flags (alu_flags),
    .err   (alu_err)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter.
//
// Directed scenarios drive the response channel and requests. A behavioural
// reference model, written with plain integer arithmetic, predicts the
// grants, the response timing and the result values on every cycle. Random
// traffic follows the directed scenarios.
module tb_alu_arbiter;

  localparam int W = 16;
  localparam longint MOD = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_out;
  logic [3:0]   rsp_flags;

  always #5 clk = ~clk;

  alu_arbiter #(.WORD_SIZE(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;

  // What each requester currently presents. hv is its valid, and refill
  // makes a requester present a fresh random op right after its grant.
  bit           hv[2];
  logic [3:0]   hop[2];
  logic [W-1:0] ha[2];
  logic [W-1:0] hb[2];
  bit           refill[2];
  bit           rr;
  bit           rstDrive;

  // Reference model state: an op is in flight from its grant until its
  // response is taken. mCyc counts clock edges since the grant.
  bit           mBusy = 1'b0;
  int           mCyc = 0;
  bit           mLast = 1'b1;
  bit           mId;
  logic [W-1:0] mOut;
  logic [3:0]   mFlags;
  bit           mErr;
  int           acceptCycle = 0;
  int           grants[$];

  // Single comparison point: counts the comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycleNo);
    end
  endtask

  function automatic longint pow2(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 2;
    return p;
  endfunction

  // Result of one operation, computed from the arithmetic meaning of the op.
  function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] out,
                                   output logic [3:0] fl, output logic err);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = ua - (a[W-1] ? MOD : 0);
    longint sb = ub - (b[W-1] ? MOD : 0);
    longint r = 0;
    longint p;
    bit c = 0;
    bit v = 0;
    err = 0;
    case (op)
      4'd0: begin
        r = ua + ub;
        c = (r >= MOD);
        v = ((sa + sb) > MOD / 2 - 1) || ((sa + sb) < -(MOD / 2));
        r = r % MOD;
      end
      4'd1: begin
        r = (ua - ub + MOD) % MOD;
        c = (ua < ub);
        v = ((sa - sb) > MOD / 2 - 1) || ((sa - sb) < -(MOD / 2));
      end
      4'd2: r = (ub >= W) ? 0 : (ua * pow2(int'(ub))) % MOD;
      4'd3: begin
        if (ub >= W) r = (sa < 0) ? -1 : 0;
        else begin
          p = pow2(int'(ub));
          r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        end
        r = (r + MOD) % MOD;
      end
      4'd4: r = (ub >= W) ? 0 : ua / pow2(int'(ub));
      4'd5: r = longint'(a & b);
      4'd6: r = longint'(a | b);
      4'd7: r = longint'(a ^ b);
      4'd8: r = (ua == ub) ? 1 : 0;
      default: err = 1;
    endcase
    out = W'(r);
    fl  = err ? 4'b0000 : {v, c, (r >= MOD / 2), (r == 0)};
  endfunction

  function automatic logic [3:0] randOp();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(9, 15));
    return 4'($urandom_range(0, 8));
  endfunction

  task automatic newReq(input int r);
    hv[r]  = 1'b1;
    hop[r] = randOp();
    ha[r]  = W'($urandom);
    hb[r]  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
    if (hop[r] == 4'd8 && $urandom_range(0, 1) == 0) hb[r] = ha[r];
  endtask

  task automatic issue(input int r, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    hv[r]  = 1'b1;
    hop[r] = op;
    ha[r]  = a;
    hb[r]  = b;
  endtask

  task automatic driveInputs();
    rst_n      = rstDrive;
    rsp_ready  = rr;
    req0_valid = hv[0];
    req0_op    = hop[0];
    req0_a     = ha[0];
    req0_b     = hb[0];
    req1_valid = hv[1];
    req1_op    = hop[1];
    req1_a     = ha[1];
    req1_b     = hb[1];
  endtask

  // One clock cycle: drive, compare every output against the model, then let
  // the model follow the rising edge, and return on the falling edge.
  task automatic applyStimulus();
    bit expR0 = 0;
    bit expR1 = 0;
    bit expV;
    bit g = 0;
    bit acc = 0;
    driveInputs();
    #1;
    if (rstDrive && !mBusy && (hv[0] || hv[1])) begin
      g = (hv[0] && hv[1]) ? !mLast : hv[1];
      if (g) expR1 = 1;
      else   expR0 = 1;
    end
    expV = rstDrive && mBusy && (mCyc >= 2);
    checkOutput("req0_ready", 32'(req0_ready), 32'(expR0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(expR1));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(expV));
    if (expV) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(mId));
      checkOutput("rsp_out", 32'(rsp_out), 32'(mOut));
      checkOutput("rsp_flags", 32'(rsp_flags), 32'(mFlags));
      checkOutput("rsp_err", 32'(rsp_err), 32'(mErr));
    end
    if (!rstDrive) begin
      mBusy = 0;
      mLast = 1;
    end else if (expR0 || expR1) begin
      mBusy = 1;
      mCyc  = 1;
      mLast = g;
      mId   = g;
      refModel(hop[g], ha[g], hb[g], mOut, mFlags, mErr);
      hv[g] = 0;
      acc   = 1;
      acceptCycle = cycleNo;
      grants.push_back(int'(g));
    end else if (mBusy) begin
      if (expV && rr) mBusy = 0;
      else            mCyc++;
    end
    @(negedge clk);
    cycleNo++;
    if (acc && refill[g]) newReq(int'(g));
  endtask

  // Runs the handshake cycle and waits for the response, then compares it
  // with the given constants and consumes it.
  task automatic expectResp(input string tag, input bit id, input logic [W-1:0] out,
                            input logic [3:0] fl, input bit err);
    int n = 0;
    applyStimulus();
    while (rsp_valid !== 1'b1 && n < 10) begin
      applyStimulus();
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " latency"}, 32'(cycleNo - acceptCycle), 32'd2);
      checkOutput({tag, " id"}, 32'(rsp_id), 32'(id));
      checkOutput({tag, " out"}, 32'(rsp_out), 32'(out));
      checkOutput({tag, " flags"}, 32'(rsp_flags), 32'(fl));
      checkOutput({tag, " err"}, 32'(rsp_err), 32'(err));
      applyStimulus();
    end
  endtask

  task automatic waitIdle(input string tag, input int bound);
    int n = 0;
    while ((hv[0] || hv[1] || mBusy) && n < bound) begin
      applyStimulus();
      n++;
    end
    if (hv[0] || hv[1] || mBusy) checkOutput({tag, " drain timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    hv = '{0, 0};
    refill = '{0, 0};
    hop = '{4'd0, 4'd0};
    ha = '{16'h0, 16'h0};
    hb = '{16'h0, 16'h0};
    rr = 1;
    rstDrive = 0;

    // Reset with both requesters valid: nothing may be accepted.
    repeat (2) applyStimulus();
    issue(0, 4'd0, 16'h1111, 16'h2222);
    issue(1, 4'd0, 16'h3333, 16'h4444);
    applyStimulus();
    driveInputs();
    #1;
    checkOutput("reset req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("reset req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset rsp_out", 32'(rsp_out), 32'd0);
    checkOutput("reset rsp_flags", 32'(rsp_flags), 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    cycleNo++;
    hv = '{0, 0};
    rstDrive = 1;

    // Arithmetic corner cases. SUB comes last so requester 1 holds the grant.
    issue(0, 4'd0, 16'h7FFF, 16'h0001);
    expectResp("add ovf", 1'b0, 16'h8000, 4'b1010, 1'b0);
    issue(0, 4'd0, 16'hFFFF, 16'h0001);
    expectResp("add carry", 1'b0, 16'h0000, 4'b0101, 1'b0);
    issue(1, 4'd1, 16'h0003, 16'h0005);
    expectResp("sub borrow", 1'b1, 16'hFFFE, 4'b0110, 1'b0);

    // Fairness: both requesters stay valid for six grants.
    s = grants.size();
    refill = '{1, 1};
    newReq(0);
    newReq(1);
    for (int i = 0; i < 40 && grants.size() < s + 6; i++) applyStimulus();
    refill = '{0, 0};
    waitIdle("fair", 20);
    for (int i = 0; i < 6; i++) begin
      if (grants.size() > s + i) checkOutput("fair id", 32'(grants[s + i]), 32'(i % 2));
      else checkOutput("fair grant missing", 32'd0, 32'd1);
    end

    // Backpressure: the response waits five cycles while both requesters are
    // valid. The cycle after it is taken, requester 1 is granted.
    rr = 0;
    issue(0, 4'd7, 16'hA5A5, 16'h0FF0);
    for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) applyStimulus();
    checkOutput("bp response", 32'(rsp_valid), 32'd1);
    newReq(0);
    newReq(1);
    repeat (5) applyStimulus();
    rr = 1;
    applyStimulus();
    driveInputs();
    #1;
    checkOutput("bp next accept", 32'(req1_ready), 32'd1);
    waitIdle("bp", 20);

    // Illegal opcode and EQUAL.
    issue(0, 4'd12, 16'h1234, 16'h5678);
    expectResp("illegal", 1'b0, 16'h0000, 4'b0000, 1'b1);
    issue(0, 4'd8, 16'h1234, 16'h1234);
    expectResp("eq same", 1'b0, 16'h0001, 4'b0000, 1'b0);
    issue(0, 4'd8, 16'h1234, 16'h1235);
    expectResp("eq diff", 1'b0, 16'h0000, 4'b0001, 1'b0);

    // Reset while requester 1's op is in EXEC: that op gets no response, and
    // requester 0 wins first afterwards.
    issue(1, 4'd0, 16'h0101, 16'h0202);
    applyStimulus();
    rstDrive = 0;
    applyStimulus();
    rstDrive = 1;
    repeat (4) begin
      applyStimulus();
      checkOutput("midrst no rsp", 32'(rsp_valid), 32'd0);
    end
    issue(0, 4'd0, 16'h0010, 16'h0020);
    issue(1, 4'd1, 16'h0030, 16'h0040);
    driveInputs();
    #1;
    checkOutput("midrst prio req0", 32'(req0_ready), 32'd1);
    checkOutput("midrst prio req1", 32'(req1_ready), 32'd0);
    applyStimulus();
    waitIdle("midrst", 20);

    // Random traffic with random backpressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++) if (!hv[r] && $urandom_range(0, 2) == 0) newReq(r);
      rr = ($urandom_range(0, 3) != 0);
      rstDrive = ($urandom_range(0, 99) != 0);
      applyStimulus();
    end
    rstDrive = 1;
    rr = 1;
    waitIdle("random", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
